// File: rtl/tt_sweep_compare_if.sv
// ----------------------------------------------------------------------------
// tt_sweep_compare_if
// Groups the request and result signals of the truth-table sweep checker.
//   N              : number of function inputs (tables are 2^N bits wide)
//   start/mode     : sweep request and check mode (0 = equal, 1 = complement)
//   tt_a/tt_b      : truth tables, bit m is the output at minterm m
//   x/fa/fb        : minterm under test and the two table bits at that minterm
//   busy/done      : scanning flag and one-cycle completion pulse
//   mismatch_count : failing minterms of the last sweep (N+1 bits, no wrap)
//   first_mismatch : lowest failing minterm, valid when first_valid is high
//   equal          : high when mismatch_count is zero
// master drives the request side, slave is the checker.
// ----------------------------------------------------------------------------
interface tt_sweep_compare_if #(
  parameter int N = 2
);
  logic                start;
  logic                mode;
  logic [(1<<N)-1:0]   tt_a;
  logic [(1<<N)-1:0]   tt_b;
  logic [N-1:0]        x;
  logic                fa;
  logic                fb;
  logic                busy;
  logic                done;
  logic [N:0]          mismatch_count;
  logic [N-1:0]        first_mismatch;
  logic                first_valid;
  logic                equal;

  modport master (
    output start, mode, tt_a, tt_b,
    input  x, fa, fb, busy, done, mismatch_count, first_mismatch,
           first_valid, equal
  );

  modport slave (
    input  start, mode, tt_a, tt_b,
    output x, fa, fb, busy, done, mismatch_count, first_mismatch,
           first_valid, equal
  );
endinterface

// File: rtl/tt_sweep_compare.sv
// ----------------------------------------------------------------------------
// tt_sweep_compare
// Sequential equivalence checker for two N-input combinational functions
// given as truth tables. On an accepted start it latches both tables and the
// mode, walks every minterm once (one per clock), and accumulates the number
// of failing minterms plus the lowest failing one.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : tt_sweep_compare_if slave modport (request in, results out)
// ----------------------------------------------------------------------------
module tt_sweep_compare #(
  parameter int N = 2
) (
  input logic               clk,
  input logic               reset,
  tt_sweep_compare_if.slave bus
);

  localparam int W = 1 << N;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e         state_q;
  logic [N-1:0]   x_q;
  logic [W-1:0]   tta_q;
  logic [W-1:0]   ttb_q;
  logic           mode_q;
  logic           busy_q;
  logic           done_q;
  logic [N:0]     cnt_q;
  logic [N-1:0]   first_q;
  logic           fvalid_q;

  logic           fa_s;
  logic           fb_s;
  logic           fail_s;
  logic           last_s;

  // Mode 0 fails on a difference; mode 1 fails when the bits agree.
  function automatic logic minterm_fail_f(input logic a, input logic b,
                                          input logic m);
    return a ^ b ^ m;
  endfunction

  assign fa_s   = tta_q[x_q];
  assign fb_s   = ttb_q[x_q];
  assign fail_s = minterm_fail_f(fa_s, fb_s, mode_q);
  assign last_s = (x_q == {N{1'b1}});

  // Sweep controller: state, minterm counter, latched request and results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= {N{1'b0}};
      tta_q    <= {W{1'b0}};
      ttb_q    <= {W{1'b0}};
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= {(N+1){1'b0}};
      first_q  <= {N{1'b0}};
      fvalid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            tta_q    <= bus.tt_a;
            ttb_q    <= bus.tt_b;
            mode_q   <= bus.mode;
            x_q      <= {N{1'b0}};
            cnt_q    <= {(N+1){1'b0}};
            first_q  <= {N{1'b0}};
            fvalid_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_SCAN;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (fail_s) begin
            // N+1 bits hold 2^N, so the count can never wrap.
            cnt_q <= cnt_q + (N+1)'(1'b1);
            if (!fvalid_q) begin
              first_q  <= x_q;
              fvalid_q <= 1'b1;
            end else begin
              fvalid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q;
          end
          if (last_s) begin
            // x parks on the last minterm until the next accepted start.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            x_q     <= x_q + N'(1'b1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.x              = x_q;
  assign bus.fa             = fa_s;
  assign bus.fb             = fb_s;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.mismatch_count = cnt_q;
  assign bus.first_mismatch = first_q;
  assign bus.first_valid    = fvalid_q;
  assign bus.equal          = (cnt_q == {(N+1){1'b0}});

endmodule

// File: doc/tt_sweep_compare.md
# tt_sweep_compare

Parametrised sequential equivalence checker for N-input combinational functions. Two functions are given as truth tables. The block sweeps every minterm with an internal counter, compares the two outputs at each minterm and reports:
- the mismatch count,
- the first failing minterm,
- a pass/fail verdict.

It generalises the two-input gate-versus-expression comparison into a self-running, width-parametrised hardware checker with an optional complement-check mode.

## Interface
- `N`, default 2: number of function inputs; legal range 1..8; truth tables are 2^N bits wide.
- `clk`  input  1  rising-edge clock, the only clock.
- `reset`  input  1  synchronous, active-high; sampled on the `clk` rising edge.
- `start`  input  1  request a sweep; honoured only in IDLE.
- `mode`  input  1  0 = equality check (fb must equal fa); 1 = complement check (fb must equal ~fa). Latched on accepted start.
- `tt_a`  input  2^N  truth table of function A; bit m is the output at minterm m. Latched on accepted start.
- `tt_b`  input  2^N  truth table of function B; same layout as `tt_a`. Latched on accepted start.
- `x`  output  N  current minterm under test; x[N-1] is the most significant input.
- `fa`  output  1  latched `tt_a` bit at index `x`; combinational from the registers.
- `fb`  output  1  latched `tt_b` bit at index `x`; combinational from the registers.
- `busy`  output  1  high while in SCAN.
- `done`  output  1  one-cycle pulse when a sweep completes.
- `mismatch_count`  output  N+1  number of failing minterms in the last sweep (0..2^N).
- `first_mismatch`  output  N  lowest failing minterm of the last sweep.
- `first_valid`  output  1  high when `first_mismatch` holds a valid minterm.
- `equal`  output  1  high when `mismatch_count` is 0; meaningful from `done` onward.

## Operation
- States are IDLE, SCAN and DONE.
- Reset values: state IDLE, `x`=0, latched tables 0, latched mode 0, `busy`=0, `done`=0, `mismatch_count`=0, `first_mismatch`=0, `first_valid`=0, `equal`=1.
- IDLE, `start`=1: latch `tt_a`, `tt_b` and `mode`; set `x`=0; clear `mismatch_count`, `first_mismatch` and `first_valid`; go to SCAN.
- IDLE, `start`=0: hold everything; results of the previous sweep stay visible.
- SCAN: each edge evaluates minterm `x`. The minterm fails when `fa`!=`fb` in mode 0, or when `fa`==`fb` in mode 1.
  - On a failure, increment `mismatch_count`.
  - If a failure occurs and `first_valid`=0, set `first_mismatch`=`x` and `first_valid`=1.
  - If `x`==2^N-1, go to DONE and leave `x` unchanged; otherwise increment `x`.
- DONE: `done`=1 for exactly one cycle, then return to IDLE. `x` holds 2^N-1 until the next accepted start.
- `start` during SCAN or DONE is ignored; it is not queued.
- Changes on `tt_a`, `tt_b` or `mode` after acceptance have no effect on a sweep in progress.
- `mismatch_count` never wraps; its maximum 2^N fits in N+1 bits.
- `equal` = (`mismatch_count`==0); this is combinational.

## Timing
- Accepted start on edge k. SCAN occupies the cycles after edges k..k+2^N-1, so `busy` is high for exactly 2^N cycles.
- `done` is high in the cycle after edge k+2^N. Total latency from start to done is 2^N+1 edges.
- `x` presents minterm i during SCAN cycle i (0-based). `fa` and `fb` are valid in the same cycle.
- Final `mismatch_count`, `first_mismatch` and `first_valid` are valid in the `done` cycle and held until the next accepted start.
- The earliest next start is accepted on the edge ending the `done` cycle plus one: IDLE must be entered first.
- Back-to-back sweeps repeat every 2^N+2 cycles with `start` held high.
- Reset mid-SCAN or in DONE: the outputs on the next cycle are the reset values. No `done` pulse is issued and the partial results are discarded.
- `reset` and `start` asserted on the same edge: reset wins and state is IDLE.

## Test plan
- Mismatch sweep: N=2, mode=0, `tt_a`=4'b0010, `tt_b`=4'b1011, pulse start.
  - `x` steps 0,1,2,3 with (fa,fb)=(0,1),(1,1),(0,0),(0,1).
  - `done` arrives 5 edges after start, with `mismatch_count`=2, `first_mismatch`=0, `first_valid`=1, `equal`=0.
- Equal tables: N=2, mode=0, `tt_a`=`tt_b`=4'b0110. Expect `mismatch_count`=0, `first_valid`=0, `equal`=1, and `busy` high for exactly 4 cycles.
- Complement mode: N=3, mode=1, `tt_a`=8'hA5, `tt_b`=8'h5A. Expect `equal`=1.
  - Then repeat with `tt_b`=8'h5B: expect `mismatch_count`=1, `first_mismatch`=0.
- Start ignored while busy: assert `start` during SCAN cycle 2 and change `tt_b` at the same time. The sweep result is unchanged, `done` pulses once, and no second sweep follows.
- Reset mid-sweep: N=3, reset in SCAN cycle 4. The next cycle shows IDLE, `x`=0, `mismatch_count`=0, `busy`=0, and no `done` pulse.
- Full mismatch: N=4, mode=0, `tt_a`=16'h0000, `tt_b`=16'hFFFF. Expect `mismatch_count`=16 (5'b10000, no wrap), `first_mismatch`=0, and `done` 17 edges after start.
